// File: rtl/mul_sched_pkg.sv
// Shared types and widths for the round-robin multiplier scheduler.
package mul_sched_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_e;

  // Latency counter must hold the value MUL_LATENCY itself.
  function automatic int unsigned cnt_width(input int unsigned latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mul_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap-around.
module mul_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_any_o
);

  int unsigned      sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    sum       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = 32'(ptr_i) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (!gnt_any_o && req_i[cand]) begin
        gnt_any_o       = 1'b1;
        gnt_idx_o       = cand;
        gnt_oh_o[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one multi-cycle signed multiplier between NUM_REQ requesters, one operation at a time.
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 34
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_x,
  input  logic [NUM_REQ*XLEN-1:0] req_y,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [PLEN-1:0]         rsp_product,
  output logic                    mul_start,
  output logic [XLEN-1:0]         mul_x,
  output logic [XLEN-1:0]         mul_y,
  input  logic [PLEN-1:0]         mul_product,
  output logic                    busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = cnt_width(MUL_LATENCY);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]      mul_x_q, mul_x_d;
  logic [XLEN-1:0]      mul_y_q, mul_y_d;
  logic [PLEN-1:0]      prod_q, prod_d;
  logic                 mul_start_q, mul_start_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

  logic                 arb_en;
  logic [NUM_REQ-1:0]   arb_req;
  logic [NUM_REQ-1:0]   arb_oh;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [XLEN-1:0]      x_arr [NUM_REQ];
  logic [XLEN-1:0]      y_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign x_arr[i] = req_x[i*XLEN +: XLEN];
    assign y_arr[i] = req_y[i*XLEN +: XLEN];
  end

  // Grants are only offered while idle and out of reset.
  assign arb_en  = (state_q == IDLE) && !rst;
  assign arb_req = req_valid & {NUM_REQ{arb_en}};

  mul_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (arb_req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .gnt_any_o (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      prod_q      <= '0;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      prod_q      <= prod_d;
      mul_start_q <= mul_start_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    prod_d      = prod_q;
    mul_start_d = 1'b0;
    busy_d      = 1'b0;
    rsp_valid_d = '0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          mul_x_d = x_arr[arb_idx];
          mul_y_d = y_arr[arb_idx];
          gnt_d   = arb_idx;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = CNT_W'(MUL_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          prod_d  = mul_product;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready[gnt_q]) begin
          ptr_d   = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs are decoded from the next state so they align with it.
    mul_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == DONE) ? (NUM_REQ'(1) << gnt_d) : '0;
  end

  assign req_ready   = arb_oh;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = prod_q;
  assign mul_start   = mul_start_q;
  assign mul_x       = mul_x_q;
  assign mul_y       = mul_y_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mul_scheduler.sv
// Self-checking bench for mul_scheduler with a behavioural multiplier and grant-order model.
module tb_mul_scheduler;

  localparam int NR = 4;
  localparam int L  = 34;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*32-1:0] req_x = '0;
  logic [NR*32-1:0] req_y = '0;
  logic [NR-1:0] rsp_valid;
  logic [NR-1:0] rsp_ready = '0;
  logic [63:0]   rsp_product;
  logic          mul_start;
  logic [31:0]   mul_x, mul_y;
  logic [63:0]   mul_product;
  logic          busy;

  int checks = 0;
  int errors = 0;

  mul_scheduler #(.NUM_REQ(NR), .MUL_LATENCY(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .mul_start   (mul_start),
    .mul_x       (mul_x),
    .mul_y       (mul_y),
    .mul_product (mul_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 64'(sa * sb);
  endfunction

  // Multiplier model: result is only correct exactly L cycles after the start cycle.
  logic [63:0] m_prod = '0;
  int          m_cyc  = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      m_cyc  <= 1;
      m_prod <= ref_mul(mul_x, mul_y);
    end else if (m_cyc != 0 && m_cyc <= L) begin
      m_cyc <= m_cyc + 1;
    end
  end
  assign mul_product = (m_cyc == L) ? m_prod : ~m_prod;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from requester r; others adds competing valids in the accept cycle.
  task automatic run_op(input int r, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input int hold, input logic [NR-1:0] others,
                        input string tag);
    logic [NR-1:0] oh;
    logic [63:0]   held;
    int n;
    int extra;
    oh = NR'(1) << r;
    req_x[r*32 +: 32] = x;
    req_y[r*32 +: 32] = y;
    req_valid = oh | others;
    @(negedge clk);
    checks++;
    if (req_ready !== oh) begin
      errors++; $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, oh);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b1 || mul_x !== x || mul_y !== y || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start: mul_start=%b mul_x=%h mul_y=%h busy=%b expected 1 %h %h 1",
               tag, mul_start, mul_x, mul_y, busy, x, y);
    end
    n = 1;
    extra = 0;
    while (n < 200) begin
      tick();
      n++;
      @(negedge clk);
      if (mul_start !== 1'b0 || req_ready !== '0) extra++;
      if (rsp_valid !== '0) break;
    end
    checks++;
    if (n != L + 2) begin
      errors++; $display("FAIL %s latency: %0d cycles expected %0d", tag, n, L + 2);
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL %s wait_quiet: %0d stray start/ready cycles expected 0", tag, extra);
    end
    checks++;
    if (rsp_valid !== oh) begin
      errors++; $display("FAIL %s rsp_valid: %b expected %b", tag, rsp_valid, oh);
    end
    checks++;
    if (rsp_product !== exp) begin
      errors++; $display("FAIL %s product: %h expected %h", tag, rsp_product, exp);
    end
    held = exp;
    for (int h = 0; h < hold; h++) begin
      req_valid = '1;
      rsp_ready = ~oh;
      tick();
      @(negedge clk);
      checks++;
      if (rsp_valid !== oh || rsp_product !== held || req_ready !== '0) begin
        errors++;
        $display("FAIL %s hold%0d: rsp_valid=%b product=%h req_ready=%b expected %b %h 0",
                 tag, h, rsp_valid, rsp_product, req_ready, oh, held);
      end
    end
    req_valid = '0;
    rsp_ready = oh;
    tick();
    rsp_ready = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s complete: rsp_valid=%b busy=%b expected 0 0", tag, rsp_valid, busy);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0 || req_ready !== '0 || mul_start !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: rsp_valid=%b req_ready=%b mul_start=%b busy=%b expected 0",
                         rsp_valid, req_ready, mul_start, busy);
    end
    checks++;
    if (mul_x !== '0 || mul_y !== '0 || rsp_product !== '0) begin
      errors++; $display("FAIL reset_data: mul_x=%h mul_y=%h product=%h expected 0", mul_x, mul_y, rsp_product);
    end
    tick();
  endtask

  task automatic test_single();
    run_op(0, 32'd3, 32'd5, 64'd15, 0, '0, "single");
  endtask

  task automatic test_signed();
    run_op(2, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 0, '0, "signed_neg");
    run_op(1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, '0, "signed_min");
  endtask

  task automatic test_backpressure();
    logic [31:0] x, y;
    x = $urandom;
    y = $urandom;
    run_op(1, x, y, ref_mul(x, y), 10, '0, "backpressure");
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    int r;
    for (int i = 0; i < 6; i++) begin
      r = int'($urandom_range(0, NR - 1));
      x = $urandom;
      y = $urandom;
      run_op(r, x, y, ref_mul(x, y), int'($urandom_range(0, 3)), '0, "random");
    end
  endtask

  task automatic test_contention();
    logic [31:0] xs [NR];
    logic [31:0] ys [NR];
    logic [NR-1:0] want;
    int mptr, g, n, viol;
    for (int i = 0; i < NR; i++) begin
      xs[i] = $urandom;
      ys[i] = $urandom;
      req_x[i*32 +: 32] = xs[i];
      req_y[i*32 +: 32] = ys[i];
    end
    rst = 1'b1;
    req_valid = '1;
    repeat (2) tick();
    rst = 1'b0;
    mptr = 0;
    for (int k = 0; k < 5; k++) begin
      g = -1;
      for (int j = 0; j < NR; j++) begin
        if (g < 0 && req_valid[(mptr + j) % NR]) g = (mptr + j) % NR;
      end
      want = NR'(1) << g;
      @(negedge clk);
      checks++;
      if (req_ready !== want) begin
        errors++; $display("FAIL contention_grant%0d: req_ready=%b expected %b", k, req_ready, want);
      end
      tick();
      n = 1;
      viol = 0;
      while (n < 200) begin
        @(negedge clk);
        if (req_ready !== '0) viol++;
        if (rsp_valid !== '0) break;
        tick();
        n++;
      end
      checks++;
      if (n != L + 2 || viol != 0) begin
        errors++; $display("FAIL contention_wait%0d: latency=%0d ready_leaks=%0d expected %0d 0",
                           k, n, viol, L + 2);
      end
      checks++;
      if (rsp_valid !== want || rsp_product !== ref_mul(xs[g], ys[g])) begin
        errors++; $display("FAIL contention_rsp%0d: rsp_valid=%b product=%h expected %b %h",
                           k, rsp_valid, rsp_product, want, ref_mul(xs[g], ys[g]));
      end
      rsp_ready = '1;
      tick();
      rsp_ready = '0;
      if (k == 4) req_valid = '0;
      mptr = (g + 1) % NR;
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] x, y;
    int bad;
    x = $urandom;
    y = $urandom;
    run_op(2, x, y, ref_mul(x, y), 0, '0, "pre_reset");
    req_x[3*32 +: 32] = $urandom;
    req_y[3*32 +: 32] = $urandom;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0 || mul_start !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL midreset_ctrl: rsp_valid=%b mul_start=%b busy=%b req_ready=%b expected 0",
                         rsp_valid, mul_start, busy, req_ready);
    end
    checks++;
    if (mul_x !== '0 || mul_y !== '0 || rsp_product !== '0) begin
      errors++; $display("FAIL midreset_data: mul_x=%h mul_y=%h product=%h expected 0", mul_x, mul_y, rsp_product);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      @(negedge clk);
      if (rsp_valid !== '0 || mul_start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midreset_abandon: %0d cycles with response/start expected 0", bad);
    end
    tick();
    x = $urandom;
    y = $urandom;
    run_op(0, x, y, ref_mul(x, y), 0, 4'b1000, "post_reset");
  endtask

  task automatic test_idle();
    int starts, busies;
    req_valid = '0;
    starts = 0;
    busies = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      @(negedge clk);
      if (mul_start !== 1'b0) starts++;
      if (busy !== 1'b0) busies++;
    end
    checks++;
    if (starts != 0) begin
      errors++; $display("FAIL idle_start: %0d pulses expected 0", starts);
    end
    checks++;
    if (busies != 0) begin
      errors++; $display("FAIL idle_busy: %0d busy cycles expected 0", busies);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_backpressure();
    test_random();
    test_contention();
    test_reset_in_wait();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
